wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Round-robin Wishbone arbiter that shares the single system bus (wb_dec and its slaves) between NM masters.
//  Master 0 is cpuif; master 1 is reserved for the planned SD/Ethernet DMA engine.
//  Sits between the masters and wb_dec.
//  Bounds bus tenure and terminates stalled cycles with a timeout ack so that no master can hang the bus.
// PARAMETERS
//  NM        2       number of masters (2..4)
//  MAX_HOLD  16      acked transfers a master may complete per tenure while another master requests
//  TIMEOUT   1024    cycles s_stb_o may stay high without s_ack_i before forced termination
// PORTS
//  clk_i          in   1      system clock (sys_clk); the only clock
//  rst_i          in   1      synchronous reset, active-low
//  m_cyc_i        in   NM     per-master cycle request
//  m_stb_i        in   NM     per-master strobe
//  m_we_i         in   NM     per-master write enable
//  m_sel_i        in   4*NM   byte selects, master k at [4k+3:4k]
//  m_adr_i        in   30*NM  word addresses, master k at [30k+29:30k]
//  m_dat_i        in   32*NM  write data, master k at [32k+31:32k]
//  m_ack_o        out  NM     ack, only ever to the granted master
//  m_dat_o        out  32     read data, shared by all masters
//  s_cyc_o/s_stb_o/s_we_o  out  1   to the slave side (wb_dec)
//  s_sel_o        out  4      to the slave side
//  s_adr_o        out  30     to the slave side
//  s_dat_o        out  32     to the slave side
//  s_ack_i        in   1      from the slave side
//  s_dat_i        in   32     from the slave side
//  grant_o        out  NM     one-hot current owner; 0 when idle
//  timeout_o      out  1      sticky: a timeout has occurred
//  timeout_clr_i  in   1      clears timeout_o
// BEHAVIOUR
//  Reset (rst_i=0 at a clock edge):
//   - state=IDLE, grant_o=0, s_cyc_o=s_stb_o=0, m_ack_o=0, timeout_o=0.
//   - Hold and timeout counters are 0; last-owner pointer is NM-1, so master 0 wins first.
//  FSM (IDLE, BUSY):
//   - IDLE: if any m_cyc_i is high, the rr_picker selects the first requester after the last owner (wrapping).
//     grant_o is registered and the FSM enters BUSY. Latency from m_cyc_i to s_cyc_o is 1 cycle.
//   - BUSY: s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g] (combinational from the registered grant).
//     s_we/sel/adr/dat_o are muxed from master g. m_ack_o[g] = s_ack_i. m_dat_o = s_dat_i.
//   - BUSY->IDLE when:
//     (a) m_cyc_i[g] falls;
//     (b) the hold counter reaches MAX_HOLD on an ack while some other m_cyc_i is high (preemption); or
//     (c) a timeout fires.
//     On exit, grant_o=0 and last-owner=g. There is always >=1 idle cycle between tenures (s_cyc_o low).
//  Preemption:
//   - The preempted master keeps cyc/stb high and sees no ack until it is re-granted.
//   - Its pending transfer is not issued in the cycle of release.
//  Hold counter:
//   - Increments on each s_ack_i in BUSY and saturates at MAX_HOLD.
//   - Clears on entry to BUSY.
//   - No preemption when no other master requests.
//  Timeout counter:
//   - Counts cycles with s_stb_o=1 and s_ack_i=0; clears on s_ack_i or on leaving BUSY.
//   - On reaching TIMEOUT-1, the next cycle forces s_cyc_o=s_stb_o=0, m_ack_o[g]=1 and m_dat_o=32'hFFFF_FFFF.
//     It also sets timeout_o and exits to IDLE.
//   - If s_ack_i arrives in the same cycle as the count reaches TIMEOUT-1, the real ack wins and there is no timeout.
//  timeout_o: set has priority over timeout_clr_i in the same cycle.
//  Master drops cyc mid-transfer (stb high, unacked): the slave sees cyc drop (abort), no ack is returned, and the FSM goes to IDLE.
//  s_ack_i while s_stb_o=0 is ignored: no m_ack_o pulse.
//  Reset mid-cycle: the bus is released immediately, next cycle s_cyc_o=0, and no ack is generated.
// STRUCTURE
//  wb_pkg:
//   - WB_ADR_W=30, WB_DAT_W=32, WB_SEL_W=4.
//   - WB_TIMEOUT_DAT=32'hFFFF_FFFF.
//   - arb_state_t {IDLE, BUSY}.
//  Sub-module rr_picker:
//   - Combinational round-robin; inputs req[NM] and last[$clog2(NM)]; outputs one-hot gnt and valid.
//  Top: FSM, counters and muxes.
// TESTING
//  1. Single master 0, 4 single reads, slave acks after 2 cycles:
//     -> s_cyc_o rises 1 cycle after m_cyc_i[0]; 4 m_ack_o[0] pulses; data passes through.
//  2. Masters 0 and 1 assert cyc in the same cycle after reset:
//     -> master 0 is granted first; after it drops cyc, 1 idle cycle, then grant_o=2'b10.
//  3. Master 0 holds a 40-transfer burst with master 1 requesting, MAX_HOLD=16:
//     -> release after the 16th ack, master 1 is granted, master 0 resumes on its next tenure with no lost or duplicated ack.
//  4. Slave never acks, TIMEOUT=8:
//     -> on the 9th stb cycle m_ack_o=1, m_dat_o=FFFF_FFFF, s_cyc_o=0 and timeout_o=1.
//     -> timeout_clr_i then clears timeout_o; with clr asserted in a timeout cycle, timeout_o stays 1.
//  5. Ack on exactly the TIMEOUT-1 cycle:
//     -> normal ack with slave data; timeout_o stays 0.
//  6. rst_i=0 during a BUSY write:
//     -> next cycle grant_o=0, s_cyc_o=0, no m_ack_o; after reset is released, master 0 has priority again.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone widths, the timeout read-data pattern and the arbiter state encoding.
// Imported by the bus interface, the round-robin picker and the arbiter top.
package wb_arbiter_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] WB_TIMEOUT_DAT = 32'hFFFF_FFFF;

    // Plain constants rather than an enum so older tools and waveform scripts see the raw encoding.
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t IDLE = 1'b0;
    localparam arb_state_t BUSY = 1'b1;

    function automatic int onehot_to_idx(input logic [3:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Master-side and slave-side Wishbone signals seen by the arbiter, plus grant/timeout status.
// The arbiter uses the slave modport; whatever drives the masters and models wb_dec uses master.
interface wb_arbiter_if #(parameter int NM = 2);
    import wb_arbiter_pkg::*;

    logic [NM-1:0]          m_cyc_i;
    logic [NM-1:0]          m_stb_i;
    logic [NM-1:0]          m_we_i;
    logic [WB_SEL_W*NM-1:0] m_sel_i;
    logic [WB_ADR_W*NM-1:0] m_adr_i;
    logic [WB_DAT_W*NM-1:0] m_dat_i;
    logic [NM-1:0]          m_ack_o;
    logic [WB_DAT_W-1:0]    m_dat_o;

    logic                   s_cyc_o;
    logic                   s_stb_o;
    logic                   s_we_o;
    logic [WB_SEL_W-1:0]    s_sel_o;
    logic [WB_ADR_W-1:0]    s_adr_o;
    logic [WB_DAT_W-1:0]    s_dat_o;
    logic                   s_ack_i;
    logic [WB_DAT_W-1:0]    s_dat_i;

    logic [NM-1:0]          grant_o;
    logic                   timeout_o;
    logic                   timeout_clr_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output m_ack_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i,
        output grant_o, timeout_o,
        input  timeout_clr_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  m_ack_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i,
        input  grant_o, timeout_o,
        output timeout_clr_i
    );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester after the last owner,
// wrapping around, so the previous owner is always considered last.
module rr_picker #(
    parameter int NM = 2,
    parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [LW-1:0] last,
    output logic [NM-1:0] gnt,
    output logic          valid
);

    logic          found;
    logic [LW-1:0] pos;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 1; i <= NM; i++) begin
            pos = LW'((int'(last) + i) % NM);
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the system bus between NM masters, with bounded tenure
// under contention and a stall timeout that terminates hung cycles with an all-ones ack.
module wb_arbiter #(
    parameter int NM       = 2,
    parameter int MAX_HOLD = 16,
    parameter int TIMEOUT  = 1024
) (
    input logic         clk_i,
    input logic         rst_i,
    wb_arbiter_if.slave bus
);
    import wb_arbiter_pkg::*;

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    arb_state_t    state;
    logic [NM-1:0] grant;
    logic [LW-1:0] grant_idx;
    logic [LW-1:0] last;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;
    logic          to_fire;
    logic          timeout_q;

    logic [NM-1:0] pick_gnt;
    logic          pick_valid;
    logic          bus_live;
    logic          ack_ok;
    logic          other_req;
    logic          preempt;
    logic          to_hit;
    logic          release_bus;

    rr_picker #(.NM(NM), .LW(LW)) u_picker (
        .req   (bus.m_cyc_i),
        .last  (last),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // The bus is only driven while a tenure is live; a forced-termination cycle or a reset
    // cycle drops cyc/stb immediately so the slave never sees a half-finished access.
    assign bus_live    = (state == BUSY) && rst_i && !to_fire;
    assign bus.s_cyc_o = bus_live && bus.m_cyc_i[grant_idx];
    assign bus.s_stb_o = bus_live && bus.m_stb_i[grant_idx];
    assign bus.s_we_o  = bus.m_we_i[grant_idx];
    assign bus.s_sel_o = bus.m_sel_i[grant_idx*WB_SEL_W +: WB_SEL_W];
    assign bus.s_adr_o = bus.m_adr_i[grant_idx*WB_ADR_W +: WB_ADR_W];
    assign bus.s_dat_o = bus.m_dat_i[grant_idx*WB_DAT_W +: WB_DAT_W];

    assign ack_ok      = bus.s_cyc_o && bus.s_stb_o && bus.s_ack_i;
    assign bus.m_ack_o = (ack_ok || (to_fire && rst_i)) ? grant : '0;
    assign bus.m_dat_o = to_fire ? WB_TIMEOUT_DAT : bus.s_dat_i;
    assign bus.grant_o   = grant;
    assign bus.timeout_o = timeout_q;

    assign other_req   = |(bus.m_cyc_i & ~grant);
    assign preempt     = ack_ok && (hold_cnt >= HOLD_LAST) && other_req;
    assign to_hit      = bus.s_cyc_o && bus.s_stb_o && !bus.s_ack_i && (to_cnt == TO_LAST);
    assign release_bus = !bus.m_cyc_i[grant_idx] || preempt || to_fire;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            last      <= LW'(NM - 1);
            hold_cnt  <= '0;
            to_cnt    <= '0;
            to_fire   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            to_fire <= 1'b0;
            // Holding the set through the forced cycle keeps a same-cycle clear from losing it.
            if (to_hit || to_fire) begin
                timeout_q <= 1'b1;
            end else if (bus.timeout_clr_i) begin
                timeout_q <= 1'b0;
            end

            if (state == IDLE) begin
                hold_cnt <= '0;
                to_cnt   <= '0;
                if (pick_valid) begin
                    state     <= BUSY;
                    grant     <= pick_gnt;
                    grant_idx <= LW'(onehot_to_idx(4'(pick_gnt)));
                end
            end else if (release_bus) begin
                state  <= IDLE;
                grant  <= '0;
                last   <= grant_idx;
                to_cnt <= '0;
            end else begin
                to_fire <= to_hit;
                if (ack_ok) begin
                    to_cnt <= '0;
                    if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                end else if (bus.s_stb_o) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for arbitration basics, then hand-written
// sequences for slave latency, preemption, timeout and reset during a tenure.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NM       = 2;
    localparam int MAX_HOLD = 16;
    localparam int TIMEOUT  = 8;

    localparam logic [29:0] ADR0 = 30'h0000_1000;
    localparam logic [29:0] ADR1 = 30'h0ABC_2000;
    localparam logic [3:0]  SEL0 = 4'h3;
    localparam logic [3:0]  SEL1 = 4'hC;
    localparam logic [31:0] DAT0 = 32'h0D0D_0000;
    localparam logic [31:0] DAT1 = 32'h1D1D_1111;

    typedef struct {
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [1:0]  we;
        logic        ack;
        logic [31:0] sdat;
        logic        clr;
        logic [1:0]  e_grant;
        logic        e_scyc;
        logic        e_sstb;
        logic [1:0]  e_mack;
        logic [31:0] e_mdat;
        logic        e_tout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   ack0_cnt = 0;
    int   a0;
    vec_t tbl [14];

    wb_arbiter_if #(.NM(NM)) bus();

    wb_arbiter #(.NM(NM), .MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected summary before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                                input logic [1:0] we, input logic ack, input logic [31:0] sdat,
                                input logic clr, input logic [1:0] e_grant, input logic e_scyc,
                                input logic e_sstb, input logic [1:0] e_mack,
                                input logic [31:0] e_mdat, input logic e_tout);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.sdat = sdat; v.clr = clr;
        v.e_grant = e_grant; v.e_scyc = e_scyc; v.e_sstb = e_sstb; v.e_mack = e_mack;
        v.e_mdat = e_mdat; v.e_tout = e_tout;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n             = v.rst;
        bus.m_cyc_i       = v.cyc;
        bus.m_stb_i       = v.stb;
        bus.m_we_i        = v.we;
        bus.s_ack_i       = v.ack;
        bus.s_dat_i       = v.sdat;
        bus.timeout_clr_i = v.clr;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the following falling edge.
    task automatic runCycle(input vec_t v, input string tag);
        int idx;
        applyStimulus(v);
        @(negedge clk);
        checkOutput({tag, " grant_o"},   32'(bus.grant_o),   32'(v.e_grant));
        checkOutput({tag, " s_cyc_o"},   32'(bus.s_cyc_o),   32'(v.e_scyc));
        checkOutput({tag, " s_stb_o"},   32'(bus.s_stb_o),   32'(v.e_sstb));
        checkOutput({tag, " m_ack_o"},   32'(bus.m_ack_o),   32'(v.e_mack));
        checkOutput({tag, " m_dat_o"},   bus.m_dat_o,        v.e_mdat);
        checkOutput({tag, " timeout_o"}, 32'(bus.timeout_o), 32'(v.e_tout));
        if (v.e_scyc) begin
            idx = v.e_grant[1] ? 1 : 0;
            checkOutput({tag, " s_adr_o"}, 32'(bus.s_adr_o), 32'((idx == 1) ? ADR1 : ADR0));
            checkOutput({tag, " s_sel_o"}, 32'(bus.s_sel_o), 32'((idx == 1) ? SEL1 : SEL0));
            checkOutput({tag, " s_dat_o"}, bus.s_dat_o,      (idx == 1) ? DAT1 : DAT0);
            checkOutput({tag, " s_we_o"},  32'(bus.s_we_o),  32'(v.we[idx]));
        end
        if (bus.m_ack_o[0]) ack0_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst cyc    stb    we     ack sdat            clr  grant  scyc sstb mack   mdat            tout
        tbl[0]  = mk(0, 2'b00, 2'b00, 2'b00, 0, 32'h1111_1111, 0, 2'b00, 0, 0, 2'b00, 32'h1111_1111, 0);
        tbl[1]  = mk(1, 2'b11, 2'b11, 2'b01, 0, 32'h2222_2222, 0, 2'b00, 0, 0, 2'b00, 32'h2222_2222, 0);
        tbl[2]  = mk(1, 2'b11, 2'b11, 2'b01, 0, 32'h3333_3333, 0, 2'b01, 1, 1, 2'b00, 32'h3333_3333, 0);
        tbl[3]  = mk(1, 2'b11, 2'b11, 2'b01, 1, 32'hA5A5_0001, 0, 2'b01, 1, 1, 2'b01, 32'hA5A5_0001, 0);
        tbl[4]  = mk(1, 2'b10, 2'b11, 2'b01, 1, 32'h4444_4444, 0, 2'b01, 0, 1, 2'b00, 32'h4444_4444, 0);
        tbl[5]  = mk(1, 2'b10, 2'b10, 2'b00, 0, 32'h5555_5555, 0, 2'b00, 0, 0, 2'b00, 32'h5555_5555, 0);
        tbl[6]  = mk(1, 2'b10, 2'b10, 2'b00, 1, 32'hB0B0_0002, 0, 2'b10, 1, 1, 2'b10, 32'hB0B0_0002, 0);
        tbl[7]  = mk(1, 2'b10, 2'b00, 2'b00, 1, 32'h6666_6666, 0, 2'b10, 1, 0, 2'b00, 32'h6666_6666, 0);
        tbl[8]  = mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h7777_7777, 0, 2'b10, 0, 0, 2'b00, 32'h7777_7777, 0);
        tbl[9]  = mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h8888_8888, 1, 2'b00, 0, 0, 2'b00, 32'h8888_8888, 0);
        tbl[10] = mk(1, 2'b11, 2'b00, 2'b00, 0, 32'h9999_9999, 0, 2'b00, 0, 0, 2'b00, 32'h9999_9999, 0);
        tbl[11] = mk(1, 2'b01, 2'b00, 2'b00, 0, 32'hAAAA_AAAA, 0, 2'b01, 1, 0, 2'b00, 32'hAAAA_AAAA, 0);
        tbl[12] = mk(1, 2'b00, 2'b00, 2'b00, 0, 32'hBBBB_BBBB, 0, 2'b01, 0, 0, 2'b00, 32'hBBBB_BBBB, 0);
        tbl[13] = mk(1, 2'b00, 2'b00, 2'b00, 0, 32'hCCCC_CCCC, 0, 2'b00, 0, 0, 2'b00, 32'hCCCC_CCCC, 0);

        bus.m_adr_i = {ADR1, ADR0};
        bus.m_sel_i = {SEL1, SEL0};
        bus.m_dat_i = {DAT1, DAT0};
        applyStimulus(mk(0, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0));
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) runCycle(tbl[i], $sformatf("vec%0d", i));

        // Single master, four reads, slave answers on the third strobe cycle.
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t1 req");
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 2; w++)
                runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'hDEAD_0000, 0, 2'b01, 1, 1, 2'b00, 32'hDEAD_0000, 0), "t1 wait");
            runCycle(mk(1, 2'b01, 2'b01, 2'b00, 1, 32'hD000_0000 + r, 0, 2'b01, 1, 1, 2'b01, 32'hD000_0000 + r, 0), "t1 ack");
        end
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b01, 0, 0, 2'b00, 32'h0, 0), "t1 drop");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t1 idle");

        // 40-transfer burst from master 0 against a competing master 1.
        a0 = ack0_cnt;
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 1, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t3 req0");
        for (int i = 0; i < 16; i++)
            runCycle(mk(1, 2'b11, 2'b11, 2'b00, 1, 32'h3000_0000 + i, 0, 2'b01, 1, 1, 2'b01, 32'h3000_0000 + i, 0), "t3 burst");
        runCycle(mk(1, 2'b11, 2'b11, 2'b00, 1, 32'h3100_0000, 0, 2'b00, 0, 0, 2'b00, 32'h3100_0000, 0), "t3 release");
        for (int i = 0; i < 3; i++)
            runCycle(mk(1, 2'b11, 2'b11, 2'b00, 1, 32'h3200_0000 + i, 0, 2'b10, 1, 1, 2'b10, 32'h3200_0000 + i, 0), "t3 m1");
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 1, 32'h3300_0000, 0, 2'b10, 0, 0, 2'b00, 32'h3300_0000, 0), "t3 m1 drop");
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 1, 32'h3400_0000, 0, 2'b00, 0, 0, 2'b00, 32'h3400_0000, 0), "t3 gap");
        for (int i = 0; i < 24; i++)
            runCycle(mk(1, 2'b01, 2'b01, 2'b00, 1, 32'h3500_0000 + i, 0, 2'b01, 1, 1, 2'b01, 32'h3500_0000 + i, 0), "t3 resume");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 1, 32'h3600_0000, 0, 2'b01, 0, 0, 2'b00, 32'h3600_0000, 0), "t3 drop");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t3 idle");
        checkOutput("t3 master0 ack total", 32'(ack0_cnt - a0), 32'd40);

        // Slave never answers: forced termination on the ninth strobe cycle.
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t4 req");
        for (int k = 1; k <= TIMEOUT; k++)
            runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'h0000_1234, 0, 2'b01, 1, 1, 2'b00, 32'h0000_1234, 0), "t4 stall");
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'h0000_1234, 1, 2'b01, 0, 0, 2'b01, 32'hFFFF_FFFF, 1), "t4 fire");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0000_1234, 0, 2'b00, 0, 0, 2'b00, 32'h0000_1234, 1), "t4 sticky");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0000_1234, 1, 2'b00, 0, 0, 2'b00, 32'h0000_1234, 1), "t4 clr");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0000_1234, 0, 2'b00, 0, 0, 2'b00, 32'h0000_1234, 0), "t4 cleared");

        // Real ack lands on the last allowed stall cycle.
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t5 req");
        for (int k = 1; k < TIMEOUT; k++)
            runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'h0000_5555, 0, 2'b01, 1, 1, 2'b00, 32'h0000_5555, 0), "t5 stall");
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 1, 32'hCAFE_0005, 0, 2'b01, 1, 1, 2'b01, 32'hCAFE_0005, 0), "t5 late ack");
        runCycle(mk(1, 2'b01, 2'b01, 2'b00, 0, 32'h0000_5556, 0, 2'b01, 1, 1, 2'b00, 32'h0000_5556, 0), "t5 no fire");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b01, 0, 0, 2'b00, 32'h0, 0), "t5 drop");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t5 idle");

        // Reset while master 0 owns the bus for a write; master 0 must win again afterwards.
        runCycle(mk(1, 2'b01, 2'b01, 2'b01, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t6 req");
        runCycle(mk(1, 2'b11, 2'b11, 2'b11, 0, 32'h6000_0000, 0, 2'b01, 1, 1, 2'b00, 32'h6000_0000, 0), "t6 write");
        runCycle(mk(0, 2'b11, 2'b11, 2'b11, 1, 32'h6000_0001, 0, 2'b01, 0, 0, 2'b00, 32'h6000_0001, 0), "t6 reset");
        runCycle(mk(1, 2'b11, 2'b11, 2'b11, 1, 32'h6000_0002, 0, 2'b00, 0, 0, 2'b00, 32'h6000_0002, 0), "t6 after");
        runCycle(mk(1, 2'b11, 2'b11, 2'b11, 1, 32'h6000_0003, 0, 2'b01, 1, 1, 2'b01, 32'h6000_0003, 0), "t6 prio");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b01, 0, 0, 2'b00, 32'h0, 0), "t6 drop");
        runCycle(mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), "t6 idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
